uart_bus_if: RTL
================

UART_BUS_IF -- requirements
Module: uart_bus_if

Interface
REQ-001 The block SHALL expose a single clock, clk, input, 1 bit, which is the CPU system clock; all state updates on its rising edge.
REQ-002 The block SHALL expose reset, input, 1 bit, asynchronous active-low reset (clears state on negedge).
REQ-003 The block SHALL expose addr, input, 32 bits, the CPU data-bus byte address.
REQ-004 The block SHALL expose wdata, input, 32 bits, the CPU write data.
REQ-005 The block SHALL expose rd and wr, inputs, 1 bit each, the CPU read and write strobes, each valid for one clk cycle.
REQ-006 The block SHALL expose rdata, output, 32 bits, the register read data.
REQ-007 The block SHALL expose TX_DATA, output, 8 bits, the byte handed to the UART sender.
REQ-008 The block SHALL expose TX_EN, output, 1 bit, the send request to the UART sender.
REQ-009 The block SHALL expose TX_STATUS, input, 1 bit, the sender busy flag (1 = busy), driven from the sampleclk domain.
REQ-010 The block SHALL expose RX_DATA, input, 8 bits, the receiver output byte.
REQ-011 The block SHALL expose RX_STATUS, input, 1 bit, the receiver byte-valid flag, driven from the sampleclk domain.
REQ-012 The block SHALL expose irq, output, 1 bit, the UART interrupt to the CPU.

Function
REQ-013 The block SHALL map its registers as follows: 0x40000018 UART_TXD (W; reads return {24'b0,TX_DATA}); 0x4000001C UART_RXD (R); 0x40000020 UART_CON (R/W).
REQ-014 UART_CON SHALL use the following bits: [0] tx_ie (RW); [1] rx_ie (RW); [2] tx_done (R, clear-on-read); [3] rx_full (R, clear-on-read); [4] tx_busy (RO, 1 whenever the TX FSM is not IDLE); [5] overrun (R, clear-on-read); [31:6] read as 0.
REQ-015 A write to UART_CON SHALL update only bits [1:0].
REQ-016 rdata SHALL be combinational from addr when rd=1.
REQ-017 rdata SHALL be 0 when rd=0 or addr is unmapped.
REQ-018 TX_STATUS and RX_STATUS SHALL each pass through a 2-flop synchronizer before use; tx_s and rx_s denote the synchronized values.
REQ-019 The TX FSM SHALL have the states IDLE, REQ, BUSY.
REQ-020 In IDLE, a wr to UART_TXD SHALL latch wdata[7:0] into TX_DATA, assert TX_EN and move to REQ on the next edge.
REQ-021 In REQ, TX_EN SHALL be held at 1 until tx_s=1; TX_EN then deasserts and the FSM moves to BUSY.
REQ-022 In BUSY, when tx_s returns to 0 the block SHALL set tx_done and return to IDLE.
REQ-023 A UART_TXD write while the TX FSM is not IDLE SHALL be discarded, leaving TX_DATA unchanged, with no error flag.
REQ-024 TX_DATA SHALL stay stable from the latching edge until the FSM is back in IDLE.
REQ-025 A rising edge of rx_s (rx_s=1, previous rx_s=0) SHALL capture RX_DATA into rx_reg and set rx_full.
REQ-026 If rx_full is already 1 at that rising edge, the block SHALL still capture the new byte and also set overrun.
REQ-027 UART_RXD reads SHALL return {24'b0, rx_reg}.
REQ-028 A read of UART_CON SHALL clear tx_done, rx_full and overrun at the end of that cycle.
REQ-029 A read of UART_RXD SHALL clear rx_full.
REQ-030 If a set event and a clear event hit the same flag in the same cycle, the set SHALL win; the read data reflects the pre-set value.
REQ-031 irq SHALL be registered and equal (tx_ie & tx_done) | (rx_ie & rx_full), updated one cycle after the flags change.

Reset
REQ-032 While reset=0, the block SHALL hold TX_EN=0, TX_DATA=0, irq=0, rx_reg=0, all UART_CON bits 0, the TX FSM in IDLE and both synchronizers at 0.
REQ-033 Reset asserted mid-transfer SHALL abort the transaction immediately, with TX_EN dropping asynchronously and no tx_done produced.
REQ-034 After reset release, the first clk edge SHALL be able to accept a UART_TXD write.

Verification
REQ-035 Send: wr UART_TXD=0x55, with the model raising TX_STATUS 3 cycles later for 20 cycles -> TX_EN=1 until tx_s=1, TX_DATA=0x55 throughout, tx_done=1 after the fall, irq=1 next cycle if tx_ie=1.
REQ-036 Busy write: second wr UART_TXD=0xAA during BUSY -> TX_DATA remains 0x55 and exactly one TX_EN episode occurs.
REQ-037 Receive: RX_DATA=0x3C with an RX_STATUS pulse -> rx_full=1, UART_RXD reads 0x3C, irq=1 with rx_ie=1, and the RXD read clears rx_full and irq.
REQ-038 Overrun: two RX_STATUS pulses (0x11 then 0x22) with no read -> rx_reg=0x22, UART_CON reads 0x28, and the next UART_CON read returns 0x00.
REQ-039 Simultaneous: UART_CON read in the same cycle as a new rx edge -> rdata bit3=0, rx_full=1 afterwards.
REQ-040 Reset mid-REQ: assert reset while TX_EN=1 -> TX_EN=0 immediately, UART_CON=0, FSM in IDLE after release.

Source files
------------

// File: rtl/uart_bus_if.sv
// CPU bus front end for the UART: memory-mapped TXD/RXD/CON registers,
// a three-state send handshake and a registered interrupt.
//
// state  | meaning
// IDLE   | no send in flight, a TXD write is accepted
// REQ    | TX_EN held high until the sender reports busy
// BUSY   | sender running, waiting for its busy flag to fall
module uart_bus_if (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] rdata,
  output logic [7:0]  TX_DATA,
  output logic        TX_EN,
  input  logic        TX_STATUS,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_STATUS,
  output logic        irq
);

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  logic [1:0] state;
  logic       tx_s1, tx_s, rx_s1, rx_s, rx_s_d;
  logic       tx_ie, rx_ie, tx_done, rx_full, overrun;
  logic [7:0] rx_reg;
  logic       txd_wr, con_wr, con_rd, rxd_rd;
  logic       tx_busy, tx_done_set, rx_edge;
  logic       unused_wdata;

  assign txd_wr       = wr && (addr == ADDR_TXD);
  assign con_wr       = wr && (addr == ADDR_CON);
  assign con_rd       = rd && (addr == ADDR_CON);
  assign rxd_rd       = rd && (addr == ADDR_RXD);
  assign tx_busy      = (state != S_IDLE);
  assign tx_done_set  = (state == S_BUSY) && !tx_s;
  assign rx_edge      = rx_s && !rx_s_d;
  assign unused_wdata = ^wdata[31:8];

  // Both status flags come from the sampleclk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_s1  <= 1'b0;
      tx_s   <= 1'b0;
      rx_s1  <= 1'b0;
      rx_s   <= 1'b0;
      rx_s_d <= 1'b0;
    end else begin
      tx_s1  <= TX_STATUS;
      tx_s   <= tx_s1;
      rx_s1  <= RX_STATUS;
      rx_s   <= rx_s1;
      rx_s_d <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      TX_EN   <= 1'b0;
      TX_DATA <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (txd_wr) begin
            TX_DATA <= wdata[7:0];
            TX_EN   <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (tx_s) begin
            TX_EN <= 1'b0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!tx_s) state <= S_IDLE;
        end
        default: begin
          TX_EN <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Set events take priority over clear-on-read in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ie   <= 1'b0;
      rx_ie   <= 1'b0;
      tx_done <= 1'b0;
      rx_full <= 1'b0;
      overrun <= 1'b0;
      rx_reg  <= 8'h00;
    end else begin
      if (con_wr) begin
        tx_ie <= wdata[0];
        rx_ie <= wdata[1];
      end
      if (tx_done_set)        tx_done <= 1'b1;
      else if (con_rd)        tx_done <= 1'b0;
      if (rx_edge)            rx_full <= 1'b1;
      else if (con_rd || rxd_rd) rx_full <= 1'b0;
      if (rx_edge && rx_full) overrun <= 1'b1;
      else if (con_rd)        overrun <= 1'b0;
      if (rx_edge)            rx_reg  <= RX_DATA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (tx_ie && tx_done) || (rx_ie && rx_full);
  end

  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      case (addr)
        ADDR_TXD: rdata = {24'h0, TX_DATA};
        ADDR_RXD: rdata = {24'h0, rx_reg};
        ADDR_CON: rdata = {26'h0, overrun, tx_busy, rx_full, tx_done, rx_ie, tx_ie};
        default:  rdata = 32'h0;
      endcase
    end
  end

endmodule
